// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register plus a blocking data-memory handshake.
// Aligned loads/stores wait in REQ until mem_ack. Misaligned ops are flagged and skip the access.
module memory_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         Branch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         valid_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic         misaligned_M,
    output logic [31:0]  stall_count
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t       state_reg, state_next;
    logic         valid_reg, branch_reg, mem_read_reg, mem_write_reg, zero_reg;
    logic [N-1:0] alu_result_reg, write_data_reg, pc_branch_reg;
    logic [N-1:0] read_data_reg, read_data_next;
    logic [31:0]  stall_count_reg;
    logic         capture;
    logic         start_access;

    // The EX/MEM register loads whenever the stage is not waiting on memory.
    assign capture      = (state_reg != REQ);
    assign start_access = valid_E & (MemRead_E | MemWrite_E) & (aluResult_E[2:0] == 3'b000);

    always_comb begin
        state_next     = state_reg;
        read_data_next = read_data_reg;
        case (state_reg)
            REQ: begin
                if (mem_ack) begin
                    state_next = DONE;
                    if (mem_read_reg) begin
                        read_data_next = mem_rdata;
                    end
                end
            end
            default: begin
                state_next = start_access ? REQ : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            read_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            read_data_reg <= read_data_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            branch_reg     <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            zero_reg       <= 1'b0;
            alu_result_reg <= '0;
            write_data_reg <= '0;
            pc_branch_reg  <= '0;
        end else if (capture) begin
            valid_reg      <= valid_E;
            branch_reg     <= Branch_E;
            mem_read_reg   <= MemRead_E;
            mem_write_reg  <= MemWrite_E;
            zero_reg       <= zero_E;
            alu_result_reg <= aluResult_E;
            write_data_reg <= writeData_E;
            pc_branch_reg  <= PCBranch_E;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall        = (state_reg == REQ);
    assign mem_req      = (state_reg == REQ);
    assign mem_we       = mem_write_reg;
    assign mem_addr     = alu_result_reg;
    assign mem_wdata    = write_data_reg;
    assign valid_M      = valid_reg & (state_reg != REQ);
    assign aluResult_M  = alu_result_reg;
    assign readData_M   = read_data_reg;
    assign PCBranch_M   = pc_branch_reg;
    assign PCSrc_M      = valid_reg & branch_reg & zero_reg;
    // Only a valid memory op can fault; bubbles never raise the flag.
    assign misaligned_M = valid_reg & (mem_read_reg | mem_write_reg) & (alu_result_reg[2:0] != 3'b000);
    assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, multi-cycle sequences,
// then randomized traffic against an instruction-level reference model.
module tb_memory_stage;
    localparam int N = 64;

    typedef struct packed {
        logic         v, br, rd, wr, z;
        logic [N-1:0] alu, wd, pcb;
    } instr_t;

    typedef struct {
        instr_t in;
        logic   ev, ep, em;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid_E, Branch_E, MemRead_E, MemWrite_E, zero_E;
    logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
    logic         stall, mem_req, mem_we, mem_ack;
    logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         valid_M, PCSrc_M, misaligned_M;
    logic [N-1:0] aluResult_M, readData_M, PCBranch_M;
    logic [31:0]  stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_t       cur     = '0;
    instr_t       m_instr = '0;
    logic         m_wait  = 1'b0;
    logic [N-1:0] m_rdata = '0;
    logic [31:0]  m_cnt   = '0;
    logic         model_on = 1'b0;

    vec_t vecs[8];

    always #5 clk = ~clk;

    memory_stage #(.N(N)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E), .Branch_E(Branch_E),
        .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .aluResult_E(aluResult_E),
        .writeData_E(writeData_E), .PCBranch_E(PCBranch_E), .zero_E(zero_E),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .valid_M(valid_M), .aluResult_M(aluResult_M), .readData_M(readData_M),
        .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M), .misaligned_M(misaligned_M),
        .stall_count(stall_count)
    );

    // Reference: an instruction either completes in one cycle or waits for its ack.
    always @(posedge clk) begin
        if (model_on) begin
            if (m_wait) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
                if (mem_ack) begin
                    m_wait <= 1'b0;
                    if (m_instr.rd) m_rdata <= mem_rdata;
                end
            end else begin
                m_instr <= cur;
                m_wait  <= cur.v & (cur.rd | cur.wr) & (cur.alu[2:0] == 3'b000);
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        cur         = i;
        valid_E     = i.v;
        Branch_E    = i.br;
        MemRead_E   = i.rd;
        MemWrite_E  = i.wr;
        zero_E      = i.z;
        aluResult_E = i.alu;
        writeData_E = i.wd;
        PCBranch_E  = i.pcb;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic instr_t mk(input logic v, br, rd, wr, z,
                                  input logic [N-1:0] alu, wd, pcb);
        instr_t i;
        i.v = v; i.br = br; i.rd = rd; i.wr = wr; i.z = z;
        i.alu = alu; i.wd = wd; i.pcb = pcb;
        return i;
    endfunction

    function automatic vec_t mkv(input instr_t i, input logic ev, ep, em);
        vec_t r;
        r.in = i; r.ev = ev; r.ep = ep; r.em = em;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind  = $urandom_range(0, 3);
        i.v   = ($urandom_range(0, 4) != 0);
        i.br  = (kind == 3);
        i.rd  = (kind == 1);
        i.wr  = (kind == 2);
        i.z   = $urandom_range(0, 1) == 1;
        i.alu = {$urandom, $urandom};
        if ($urandom_range(0, 2) != 0) i.alu[2:0] = 3'b000;
        i.wd  = {$urandom, $urandom};
        i.pcb = {$urandom, $urandom};
        return i;
    endfunction

    task automatic load_store(input logic is_store, input logic [N-1:0] addr, input logic [N-1:0] wd);
        drive(mk(1'b1, 1'b0, !is_store, is_store, 1'b0, addr, wd, '0));
    endtask

    initial begin
        vecs[0] = mkv(mk(1, 0, 0, 0, 0, 64'hFF00_0000_0000_0000, 64'h1, 64'h2), 1, 0, 0);
        vecs[1] = mkv(mk(1, 1, 0, 0, 1, 64'h0, 64'h0, 64'hFC00_0000_0000_003D), 1, 1, 0);
        vecs[2] = mkv(mk(1, 1, 0, 0, 0, 64'h4, 64'h0, 64'hFC00_0000_0000_003D), 1, 0, 0);
        vecs[3] = mkv(mk(1, 0, 1, 0, 0, 64'h3, 64'h0, 64'h0), 1, 0, 1);
        vecs[4] = mkv(mk(1, 0, 0, 1, 0, 64'h15, 64'hAA, 64'h0), 1, 0, 1);
        vecs[5] = mkv(mk(0, 1, 1, 0, 1, 64'h10, 64'h0, 64'h40), 0, 0, 0);
        vecs[6] = mkv(mk(0, 0, 0, 1, 0, 64'h7, 64'h0, 64'h0), 0, 0, 0);
        vecs[7] = mkv(mk(1, 0, 0, 0, 1, 64'h8, 64'h0, 64'h0), 1, 0, 0);

        mem_ack = 1'b0; mem_rdata = '0; drive('0);
        #1 reset = 1'b1;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_valid_M", valid_M, 0);
        check("rst_pcsrc", PCSrc_M, 0);
        check("rst_misaligned", misaligned_M, 0);
        check("rst_readData", readData_M, 0);
        check("rst_stall_count", stall_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].in);
            tick();
            $display("vector %0d: valid_M=%b PCSrc_M=%b misaligned_M=%b", i, valid_M, PCSrc_M, misaligned_M);
            check("vec_valid_M", valid_M, vecs[i].ev);
            check("vec_pcsrc", PCSrc_M, vecs[i].ep);
            check("vec_misaligned", misaligned_M, vecs[i].em);
            check("vec_mem_req", mem_req, 0);
            check("vec_stall", stall, 0);
            check("vec_aluResult", aluResult_M, vecs[i].in.alu);
            check("vec_PCBranch", PCBranch_M, vecs[i].in.pcb);
            check("vec_readData", readData_M, 0);
        end

        // Load with ack two cycles after the request rises.
        load_store(1'b0, 64'h10, 64'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check("ld_mem_req", mem_req, 1);
            check("ld_stall", stall, 1);
            check("ld_mem_we", mem_we, 0);
            check("ld_mem_addr", mem_addr, 64'h10);
            check("ld_valid_M", valid_M, 0);
            if (k == 2) begin mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF; end
            tick();
        end
        mem_ack = 1'b0;
        $display("load 0x10: readData_M=%h stall_count=%0d", readData_M, stall_count);
        check("ld_done_req", mem_req, 0);
        check("ld_done_stall", stall, 0);
        check("ld_done_valid", valid_M, 1);
        check("ld_readData", readData_M, 64'hDEAD_BEEF);
        check("ld_stall_count", stall_count, 3);

        // Store, ack in the second request cycle.
        load_store(1'b1, 64'h8, 64'h0F);
        tick();
        check("st_mem_req", mem_req, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 64'h8);
        check("st_mem_wdata", mem_wdata, 64'h0F);
        tick();
        check("st_stall", stall, 1);
        mem_ack = 1'b1; mem_rdata = 64'h1234;
        tick();
        mem_ack = 1'b0;
        $display("store 0x8: readData_M=%h stall_count=%0d", readData_M, stall_count);
        check("st_done_valid", valid_M, 1);
        check("st_done_stall", stall, 0);
        check("st_readData", readData_M, 64'hDEAD_BEEF);
        check("st_stall_count", stall_count, 5);

        // Spurious ack on the capture edge is ignored; then a zero-wait ack.
        load_store(1'b0, 64'h20, 64'h0);
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        tick();
        check("sp_mem_req", mem_req, 1);
        check("sp_mem_addr", mem_addr, 64'h20);
        check("sp_readData", readData_M, 64'hDEAD_BEEF);
        mem_rdata = 64'h55;
        tick();
        mem_ack = 1'b0;
        $display("load 0x20 zero-wait: readData_M=%h", readData_M);
        check("zw_stall", stall, 0);
        check("zw_valid", valid_M, 1);
        check("zw_readData", readData_M, 64'h55);
        check("zw_stall_count", stall_count, 6);

        // Back-to-back load sees its own request.
        load_store(1'b0, 64'h28, 64'h0);
        tick();
        check("b2b_mem_req", mem_req, 1);
        check("b2b_mem_addr", mem_addr, 64'h28);
        mem_ack = 1'b1; mem_rdata = 64'h77;
        tick();
        mem_ack = 1'b0;
        $display("load 0x28 back-to-back: readData_M=%h", readData_M);
        check("b2b_readData", readData_M, 64'h77);
        check("b2b_stall_count", stall_count, 7);

        // Reset in the middle of a request with a coincident ack.
        load_store(1'b0, 64'h30, 64'h0);
        tick();
        check("mr_mem_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 64'h99;
        #2 reset = 1'b1;
        #1;
        $display("reset mid-request: mem_req=%b stall=%b", mem_req, stall);
        check("mr_req_drop", mem_req, 0);
        check("mr_stall_drop", stall, 0);
        check("mr_valid_M", valid_M, 0);
        check("mr_readData", readData_M, 0);
        check("mr_stall_count", stall_count, 0);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0; drive('0);
        tick();
        check("mr_post_req", mem_req, 0);
        check("mr_post_stall", stall, 0);
        check("mr_post_readData", readData_M, 0);
        check("mr_post_count", stall_count, 0);

        // Randomized traffic against the reference model.
        model_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            mem_rdata = {$urandom, $urandom};
            if (m_wait) mem_ack = ($urandom_range(0, 2) == 0);
            else        mem_ack = ($urandom_range(0, 5) == 0);
            if (!m_wait) drive(rand_instr());
            tick();
            check("rnd_stall", stall, m_wait);
            check("rnd_mem_req", mem_req, m_wait);
            if (m_wait) begin
                check("rnd_mem_we", mem_we, m_instr.wr);
                check("rnd_mem_addr", mem_addr, m_instr.alu);
                check("rnd_mem_wdata", mem_wdata, m_instr.wd);
            end
            check("rnd_valid_M", valid_M, m_instr.v & !m_wait);
            check("rnd_pcsrc", PCSrc_M, m_instr.v & m_instr.br & m_instr.z);
            check("rnd_misaligned", misaligned_M,
                  m_instr.v & (m_instr.rd | m_instr.wr) & (m_instr.alu[2:0] != 3'b000));
            check("rnd_aluResult", aluResult_M, m_instr.alu);
            check("rnd_PCBranch", PCBranch_M, m_instr.pcb);
            check("rnd_readData", readData_M, m_rdata);
            check("rnd_stall_count", stall_count, m_cnt);
        end
        mem_ack = 1'b0;
        $display("random phase: %0d stall cycles observed", stall_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
